// File: rtl/uart_tx_line_arbiter.sv
// Round-robin arbiter that lends one UART TX byte channel to a single requester
// at a time, holding the grant for a whole line (up to 0x0A) or until the owner goes quiet.
module uart_tx_line_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit LINE_LOCK_EN   = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                     state;
    logic [PTR_W-1:0]           owner;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           pick;
    logic [PTR_W-1:0]           next_ptr;
    logic [CNT_W-1:0]           idle_cnt;
    logic [NUM_REQ-1:0][7:0]    data_arr;
    logic                       locked;
    logic                       own_valid;
    logic [7:0]                 own_data;
    logic                       xfer;
    logic                       release_line;
    logic                       timeout_hit;

    assign data_arr  = req_data_i;
    // Reset drops the grant in the same cycle so no byte slips through.
    assign locked    = (state == LOCKED) && !rst_i;
    assign own_valid = req_valid_i[owner];
    assign own_data  = data_arr[owner];

    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        if (locked) begin
            req_ready_o[owner] = tx_ready_i;
            grant_o[owner]     = 1'b1;
            tx_valid_o         = own_valid;
            tx_data_o          = own_data;
        end
    end

    assign busy_o       = locked;
    assign xfer         = tx_valid_o && tx_ready_i;
    assign release_line = LINE_LOCK_EN ? (xfer && own_data == 8'h0A) : xfer;
    assign timeout_hit  = locked && !own_valid &&
                          (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign next_ptr     = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // First valid requester at or above rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        logic [PTR_W:0] idx;
        pick = '0;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQ))
                idx = idx - (PTR_W+1)'(NUM_REQ);
            if (req_valid_i[idx[PTR_W-1:0]])
                pick = idx[PTR_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            idle_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        owner    <= pick;
                        state    <= LOCKED;
                        idle_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (release_line || timeout_hit) begin
                        state     <= IDLE;
                        rr_ptr    <= next_ptr;
                        idle_cnt  <= '0;
                        timeout_o <= timeout_hit;
                    end else if (own_valid) begin
                        // A valid-but-stalled owner is never considered idle.
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Scoreboard bench: a line-level round-robin model predicts (owner, byte) order;
// a monitor process checks every transfer plus per-cycle handshake rules.
module tb_uart_tx_line_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout;

    uart_tx_line_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO), .LINE_LOCK_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
        .tx_ready_i(tx_ready), .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_q[$];
    logic [7:0] src[N][$];
    int         gap[N];
    bit         mon_on = 1'b0;
    bit         tmo_ok = 1'b0;
    int         model_ptr = 0;
    bit         exp_bub = 1'b0;
    bit         exp_gnt = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        int r = -1;
        int c = 0;
        for (int i = 0; i < N; i++) if (v[i]) begin r = i; c++; end
        return (c == 1) ? r : -1;
    endfunction

    // Monitor: pops the scoreboard on every transfer and checks cycle rules.
    always @(negedge clk) begin
        if (rst || !mon_on) begin
            exp_bub = 1'b0;
            exp_gnt = 1'b0;
        end else begin
            if (exp_bub) chk("bubble_after_lf", int'(busy), 0);
            if (exp_gnt) chk("grant_after_one_bubble", int'(busy), 1);
            if (!tmo_ok) chk("no_spurious_timeout", int'(timeout), 0);
            chk("req_ready_rule", int'(req_ready),
                int'(busy ? (grant & {N{tx_ready}}) : {N{1'b0}}));
            exp_bub = 1'b0;
            exp_gnt = !busy && (req_valid != '0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("unexpected_xfer", int'(tx_data), -1);
                else chk("xfer_owner_data", oh2i(grant) * 256 + int'(tx_data), exp_q.pop_front());
                exp_bub = (tx_data == 8'h0A);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        tx_ready = 1'b0;
        for (int k = 0; k < N; k++) begin src[k].delete(); gap[k] = 0; end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic gen_lines();
        logic [7:0] b;
        for (int k = 0; k < N; k++) begin
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(0, 4)) begin
                    b = 8'($urandom);
                    if (b == 8'h0A) b = 8'h0B;
                    src[k].push_back(b);
                end
                src[k].push_back(8'h0A);
            end
        end
    endtask

    // Reference: whole lines granted round-robin among requesters with data left.
    task automatic model_lines();
        logic [7:0] q[N][$];
        logic [7:0] b;
        bit found;
        int k;
        for (int i = 0; i < N; i++) q[i] = src[i];
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int i = 0; i < N && !found; i++) begin
                k = (model_ptr + i) % N;
                if (q[k].size() > 0) begin
                    do begin
                        b = q[k].pop_front();
                        exp_q.push_back(k * 256 + int'(b));
                    end while (b != 8'h0A);
                    model_ptr = (k + 1) % N;
                    found = 1'b1;
                end
            end
        end
    endtask

    // Drives the preloaded src queues; mode 1 = tx_ready always high, 0 = random.
    task automatic run_streams(input int rdy_mode, input bit gaps, output int cyc);
        logic [N-1:0] acc;
        bit done;
        model_lines();
        acc = '0;
        cyc = 0;
        done = 1'b0;
        for (int it = 0; it < 5000 && !done; it++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    if (src[k].size() > 0 && src[k].pop_front() != 8'h0A && gaps &&
                        $urandom_range(0, 2) == 0)
                        gap[k] = $urandom_range(1, 10);
                end else if (gap[k] > 0) begin
                    gap[k]--;
                end
                req_valid[k] = (src[k].size() > 0) && (gap[k] == 0);
                req_data[8*k +: 8] = req_valid[k] ? src[k][0] : 8'($urandom);
            end
            tx_ready = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            done = (exp_q.size() == 0) && (req_valid == '0);
            for (int k = 0; k < N; k++) if (src[k].size() > 0) done = 1'b0;
            if (!done) begin
                cyc++;
                @(negedge clk);
                acc = req_valid & req_ready;
            end
        end
        chk("stream_completed", int'(done), 1);
        req_valid = '0;
        for (int k = 0; k < N; k++) begin src[k].delete(); gap[k] = 0; end
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int first;
        int pulses;
        int bad_t;
        int bad_r;
        int bad_d;
        int bad_b;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        do_reset();
        mon_on = 1'b1;

        // "Hi\n" from req1: one bubble then three back-to-back bytes
        src[1] = '{8'h48, 8'h69, 8'h0A};
        run_streams(1, 1'b0, cyc);
        chk("hi_cycles", cyc, 4);

        // Contention: two lines, atomic, exactly one bubble between them
        do_reset();
        src[0] = '{8'h41, 8'h42, 8'h0A};
        src[2] = '{8'h43, 8'h44, 8'h0A};
        run_streams(1, 1'b0, cyc);
        chk("contention_cycles", cyc, 8);
        // rr pointer left at 3: next round must start at requester 3
        for (int k = 0; k < N; k++) src[k] = '{8'h0A};
        run_streams(1, 1'b0, cyc);
        chk("rr_after_contention_cycles", cyc, 8);

        // Fairness 0,1,2,3,0
        do_reset();
        src[0] = '{8'h0A, 8'h0A};
        for (int k = 1; k < N; k++) src[k] = '{8'h0A};
        run_streams(1, 1'b0, cyc);
        chk("rr_cycles", cyc, 10);

        // Random lines, random backpressure, short mid-line owner gaps
        for (int r = 0; r < 6; r++) begin
            gen_lines();
            run_streams(0, 1'b1, cyc);
        end

        // Timeout: req1 sends one byte then goes silent, req3 waits
        do_reset();
        tmo_ok = 1'b1;
        exp_q.push_back(1 * 256 + 8'h41);
        exp_q.push_back(3 * 256 + 8'h0A);
        req_valid = 4'b1010;
        req_data[8 +: 8] = 8'h41;
        req_data[24 +: 8] = 8'h0A;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("tmo_owner1", int'(grant), 4'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        first = -1;
        pulses = 0;
        for (int t = 0; t <= TMO + 1; t++) begin
            @(negedge clk);
            if (timeout) begin
                pulses++;
                if (first < 0) first = t;
            end
            if (t < TMO) chk("tmo_grant_held", int'(grant), 4'b0010);
            if (t == TMO + 1) chk("tmo_regrant_req3", int'(grant), 4'b1000);
        end
        chk("tmo_cycle", first, TMO);
        chk("tmo_pulses", pulses, 1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_scoreboard_drained", exp_q.size(), 0);
        tmo_ok = 1'b0;

        // Backpressure: 2000 stalled cycles must not time out
        do_reset();
        exp_q.push_back(0 * 256 + 8'h55);
        exp_q.push_back(0 * 256 + 8'h0A);
        req_valid = 4'b0001;
        req_data[7:0] = 8'h55;
        @(negedge clk);
        bad_t = 0; bad_r = 0; bad_d = 0; bad_b = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (timeout) bad_t++;
            if (req_ready != '0) bad_r++;
            if (tx_data != 8'h55 || !tx_valid) bad_d++;
            if (grant != 4'b0001) bad_b++;
        end
        chk("bp_no_timeout", bad_t, 0);
        chk("bp_ready_low", bad_r, 0);
        chk("bp_data_stable", bad_d, 0);
        chk("bp_grant_held", bad_b, 0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_ready", int'(req_ready), 4'b0001);
        @(posedge clk); #1;
        req_data[7:0] = 8'h0A;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_scoreboard_drained", exp_q.size(), 0);

        // Reset mid-line on req2, then req0 must win over req2
        do_reset();
        exp_q.push_back(2 * 256 + 8'h31);
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'h31;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_data[16 +: 8] = 8'h32;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_accept", int'(req_ready), 0);
        chk("rst_mid_scoreboard", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
        exp_q.push_back(0 * 256 + 8'h0A);
        req_valid = 4'b0101;
        req_data[7:0] = 8'h0A;
        @(negedge clk);
        chk("rst_mid_grant_cleared", int'(grant), 0);
        chk("rst_mid_tx_valid", int'(tx_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_req0_wins", int'(grant), 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
